fifo_rd_ptr_ctrl: RTL

Read-side pointer and status controller for the asynchronous FIFO. It runs in the read clock domain, owns the read address into the dual-port memory, and publishes the Gray-coded read pointer. The Synchronizer carries that pointer into the write domain, and another Synchronizer instance returns the write pointer into this block. From the synchronized write pointer the block derives empty, almost-empty, fill level and a sticky underflow error.

---
 rtl/fifo_pkg.sv | 32 +++
 rtl/fifo_rd_ptr_ctrl_if.sv | 35 +++
 rtl/fifo_rd_ptr_ctrl_gray_to_bin.sv | 22 ++
 rtl/fifo_rd_ptr_ctrl.sv | 101 ++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the asynchronous FIFO read- and write-side pointer
// controllers.
//   FIFO_ADDR_W : default memory address width (depth = 2**FIFO_ADDR_W)
//   PTR_MAX_W   : widest pointer the conversion helpers accept
//   bin2gray()  : binary -> Gray code
//   gray2bin()  : Gray code -> binary
// Both helpers are width-agnostic. Callers zero-extend a narrower pointer to
// PTR_MAX_W and truncate the result. Leading zeros do not change either
// conversion.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_ADDR_W = 5;
    localparam int PTR_MAX_W   = 32;

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Binary bit i is the XOR of every Gray bit at position i and above.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b = '0;
        for (int i = 0; i < PTR_MAX_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ptr_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_ptr_ctrl_if
// Bundles the signals between the read-side pointer controller and its
// surroundings: the memory, the synchronizers and the consumer.
//   rd_en, wq2_wptr, clr_err           : into the controller
//   raddr, rptr, empty, almost_empty,
//   rd_level, underflow                : out of the controller
// Modport slave is the controller. Modport master is the logic around it.
// -----------------------------------------------------------------------------
interface fifo_rd_ptr_ctrl_if
    import fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W
);
    logic              rd_en;
    logic [ADDR_W:0]   wq2_wptr;
    logic              clr_err;
    logic [ADDR_W-1:0] raddr;
    logic [ADDR_W:0]   rptr;
    logic              empty;
    logic              almost_empty;
    logic [ADDR_W:0]   rd_level;
    logic              underflow;

    modport master (
        output rd_en, wq2_wptr, clr_err,
        input  raddr, rptr, empty, almost_empty, rd_level, underflow
    );

    modport slave (
        input  rd_en, wq2_wptr, clr_err,
        output raddr, rptr, empty, almost_empty, rd_level, underflow
    );

endinterface

// File: rtl/fifo_rd_ptr_ctrl_gray_to_bin.sv
// -----------------------------------------------------------------------------
// gray_to_bin
// Combinational Gray-to-binary converter (prefix XOR from the MSB down).
//   W      : pointer width
//   i_gray : Gray-coded input
//   o_bin  : binary equivalent
// -----------------------------------------------------------------------------
module gray_to_bin
    import fifo_pkg::*;
#(
    parameter int W = FIFO_ADDR_W + 1
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    // Each bit is reduced independently, so there is no ripple through o_bin.
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[W-1:i];
    end

endmodule

// File: rtl/fifo_rd_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ptr_ctrl
// Read-side pointer and status controller of the asynchronous FIFO, in the
// read clock domain.
//   clk  : read-domain clock
//   rst  : synchronous, active-high reset
//   bus  : fifo_rd_ptr_ctrl_if.slave
//          rd_en        pop request
//          wq2_wptr     Gray write pointer, already synchronized into clk
//          clr_err      clears underflow
//          raddr        binary read address to the memory
//          rptr         Gray read pointer toward the write domain
//          empty        FIFO empty
//          almost_empty level <= AE_TH
//          rd_level     entries available, 0..2**ADDR_W
//          underflow    sticky: a pop was attempted while empty
// All outputs are registered. The status flags are computed from the
// next-state pointer, so a pop and its effect on empty/level land on the
// same edge.
// -----------------------------------------------------------------------------
module fifo_rd_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W,
    parameter int AE_TH  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_rd_ptr_ctrl_if.slave    bus
);

    localparam int              PTR_W  = ADDR_W + 1;
    localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_TH);

    logic [PTR_W-1:0]  r_rbin;
    logic [PTR_W-1:0]  r_rptr;
    logic [ADDR_W-1:0] r_raddr;
    logic              r_empty;
    logic              r_almost_empty;
    logic [PTR_W-1:0]  r_rd_level;
    logic              r_underflow;

    logic              w_pop;
    logic              w_underflow_set;
    logic [PTR_W-1:0]  w_rbin_next;
    logic [PTR_W-1:0]  w_rgray_next;
    logic [PTR_W-1:0]  w_wbin;
    logic [PTR_W-1:0]  w_level_next;

    gray_to_bin #(
        .W (PTR_W)
    ) u_gray_to_bin (
        .i_gray (bus.wq2_wptr),
        .o_bin  (w_wbin)
    );

    // A pop is accepted only against the registered empty flag. A request
    // while empty is recorded as underflow and leaves the pointer alone.
    assign w_pop           = bus.rd_en & ~r_empty;
    assign w_underflow_set = bus.rd_en &  r_empty;

    assign w_rbin_next  = r_rbin + PTR_W'(w_pop);
    assign w_rgray_next = PTR_W'(bin2gray(PTR_MAX_W'(w_rbin_next)));

    // Modulo subtraction. When the pointers have different MSBs and equal
    // LSBs, the result is exactly 2**ADDR_W (full).
    assign w_level_next = w_wbin - w_rbin_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rbin         <= '0;
            r_rptr         <= '0;
            r_raddr        <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_rd_level     <= '0;
            r_underflow    <= 1'b0;
        end else begin
            r_rbin         <= w_rbin_next;
            r_rptr         <= w_rgray_next;
            r_raddr        <= w_rbin_next[ADDR_W-1:0];
            r_empty        <= (w_rgray_next == bus.wq2_wptr);
            r_almost_empty <= (w_level_next <= AE_LVL);
            r_rd_level     <= w_level_next;
            // When set and clear occur in the same cycle, set wins.
            if (w_underflow_set) begin
                r_underflow <= 1'b1;
            end else if (bus.clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign bus.raddr        = r_raddr;
    assign bus.rptr         = r_rptr;
    assign bus.empty        = r_empty;
    assign bus.almost_empty = r_almost_empty;
    assign bus.rd_level     = r_rd_level;
    assign bus.underflow    = r_underflow;

endmodule
